// File: rtl/pipe_pkg.sv
// Shared types for the EX->MEM pipeline register and its skid buffer.
package pipe_pkg;

    localparam int unsigned DEF_XLEN    = 32;
    localparam int unsigned DEF_RADDR_W = 5;
    localparam int unsigned REG_ZERO    = 0;

    // Control bits carried alongside each instruction.
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } ex_mem_ctrl_t;

    localparam int unsigned CTRL_W = $bits(ex_mem_ctrl_t);

    // Full payload at default widths; the top packs the same field order flat.
    typedef struct packed {
        ex_mem_ctrl_t                ctrl;
        logic [DEF_RADDR_W-1:0]      rd;
        logic [DEF_XLEN-1:0]         alu_result;
        logic [DEF_XLEN-1:0]         store_data;
    } ex_mem_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer with synchronous flush; head slot drives the output.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    stage_state_t     state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             accept;
    logic             retire;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_q;
    assign in_ready  = in_ready_q;
    assign occupancy = state_q;
    assign accept    = in_valid & in_ready_q;
    assign retire    = out_valid & out_ready;

    // Next-state and slot updates; flush wins and leaves payloads untouched.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && retire) begin
                        head_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (retire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (retire) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != FULL);
    end

    // State, slot and ready registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline register: handshake, stall/flush, control gating and hazard export.
module ex_mem_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN              = 32,
    parameter int unsigned RADDR_W           = 5,
    parameter bit          ZERO_REG_WRITABLE = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    alu_result_in,
    input  logic [XLEN-1:0]    store_data_in,
    input  logic [RADDR_W-1:0] rd_in,
    input  logic               mem_read_in,
    input  logic               mem_write_in,
    input  logic               mem_to_reg_in,
    input  logic               reg_write_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    mem_addr_out,
    output logic [XLEN-1:0]    write_data_out,
    output logic [RADDR_W-1:0] rd_out,
    output logic               mem_read_out,
    output logic               mem_write_out,
    output logic               mem_to_reg_out,
    output logic               reg_write_out,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]    fwd_data,
    output logic               load_pending,
    output logic [1:0]         occupancy
);

    localparam int unsigned PAYLOAD_W = CTRL_W + RADDR_W + 2 * XLEN;

    ex_mem_ctrl_t          in_ctrl;
    ex_mem_ctrl_t          head_ctrl;
    logic [RADDR_W-1:0]    head_rd;
    logic [XLEN-1:0]       head_alu;
    logic [XLEN-1:0]       head_store;
    logic [PAYLOAD_W-1:0]  in_payload;
    logic [PAYLOAD_W-1:0]  head_payload;
    logic                  rd_nonzero;
    logic                  rd_writable;

    // Pack the EX-side fields into one flat payload.
    assign in_ctrl.mem_read   = mem_read_in;
    assign in_ctrl.mem_write  = mem_write_in;
    assign in_ctrl.mem_to_reg = mem_to_reg_in;
    assign in_ctrl.reg_write  = reg_write_in;
    assign in_payload = {in_ctrl, rd_in, alu_result_in, store_data_in};

    pipe_skid_buf #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_payload),
        .occupancy (occupancy)
    );

    assign {head_ctrl, head_rd, head_alu, head_store} = head_payload;

    // A write to the zero register is a no-op unless the core allows it.
    assign rd_nonzero  = (head_rd != RADDR_W'(REG_ZERO));
    assign rd_writable = ZERO_REG_WRITABLE | rd_nonzero;

    // Data outputs straight from the head slot.
    assign mem_addr_out   = head_alu;
    assign write_data_out = head_store;
    assign rd_out         = head_rd;

    // Controls are killed on empty/flushed slots so bubbles have no side effects.
    assign mem_read_out   = out_valid & head_ctrl.mem_read;
    assign mem_write_out  = out_valid & head_ctrl.mem_write;
    assign mem_to_reg_out = out_valid & head_ctrl.mem_to_reg;
    assign reg_write_out  = out_valid & head_ctrl.reg_write & rd_writable;

    // Hazard info: ALU results forward now, loads force EX to stall dependants.
    assign fwd_valid    = out_valid & head_ctrl.reg_write & ~head_ctrl.mem_to_reg & rd_writable;
    assign fwd_rd       = head_rd;
    assign fwd_data     = head_alu;
    assign load_pending = out_valid & head_ctrl.mem_to_reg & head_ctrl.reg_write & rd_nonzero;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed plus random bench for ex_mem_stage_reg against a queue-based model.
module tb_ex_mem_stage_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result_in;
    logic [31:0] store_data_in;
    logic [4:0]  rd_in;
    logic        mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] mem_addr_out;
    logic [31:0] write_data_out;
    logic [4:0]  rd_out;
    logic        mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        load_pending;
    logic [1:0]  occupancy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        mr, mw, m2r, rw;
        logic [4:0]  rd;
        logic [31:0] alu, sd;
    } ent_t;

    ent_t q[$];

    always #5 clk = ~clk;

    ex_mem_stage_reg dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_result_in  (alu_result_in),
        .store_data_in  (store_data_in),
        .rd_in          (rd_in),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .mem_to_reg_in  (mem_to_reg_in),
        .reg_write_in   (reg_write_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .mem_addr_out   (mem_addr_out),
        .write_data_out (write_data_out),
        .rd_out         (rd_out),
        .mem_read_out   (mem_read_out),
        .mem_write_out  (mem_write_out),
        .mem_to_reg_out (mem_to_reg_out),
        .reg_write_out  (reg_write_out),
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data),
        .load_pending   (load_pending),
        .occupancy      (occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output with what the model queue says the head should show.
    task automatic check_all(input string tag);
        ent_t h;
        chk({tag, ":occupancy"}, 64'(occupancy), 64'(q.size()));
        chk({tag, ":in_ready"}, 64'(in_ready), 64'(q.size() != 2));
        chk({tag, ":out_valid"}, 64'(out_valid), 64'(q.size() != 0));
        if (q.size() == 0) begin
            chk({tag, ":ctrl_idle"},
                64'({mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out}), 64'(0));
            chk({tag, ":hazard_idle"}, 64'({fwd_valid, load_pending}), 64'(0));
        end else begin
            h = q[0];
            chk({tag, ":addr"}, 64'(mem_addr_out), 64'(h.alu));
            chk({tag, ":wdata"}, 64'(write_data_out), 64'(h.sd));
            chk({tag, ":rd"}, 64'(rd_out), 64'(h.rd));
            chk({tag, ":mem_read"}, 64'(mem_read_out), 64'(h.mr));
            chk({tag, ":mem_write"}, 64'(mem_write_out), 64'(h.mw));
            chk({tag, ":mem_to_reg"}, 64'(mem_to_reg_out), 64'(h.m2r));
            chk({tag, ":reg_write"}, 64'(reg_write_out), 64'(h.rw && h.rd != 0));
            chk({tag, ":fwd_valid"}, 64'(fwd_valid), 64'(h.rw && !h.m2r && h.rd != 0));
            chk({tag, ":fwd_rd"}, 64'(fwd_rd), 64'(h.rd));
            chk({tag, ":fwd_data"}, 64'(fwd_data), 64'(h.alu));
            chk({tag, ":load_pending"}, 64'(load_pending), 64'(h.m2r && h.rw && h.rd != 0));
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic step(input string tag, input logic iv, input logic [31:0] a,
                        input logic [31:0] s, input logic [4:0] r,
                        input logic [3:0] ctl, input logic ordy, input logic fl);
        ent_t e;
        logic acc, ret;
        in_valid      = iv;
        alu_result_in = a;
        store_data_in = s;
        rd_in         = r;
        {mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in} = ctl;
        out_ready     = ordy;
        flush         = fl;
        e.mr = ctl[3]; e.mw = ctl[2]; e.m2r = ctl[1]; e.rw = ctl[0];
        e.rd = r; e.alu = a; e.sd = s;
        @(posedge clk);
        acc = iv && (q.size() != 2);
        ret = ordy && (q.size() != 0);
        if (fl) begin
            q.delete();
        end else begin
            if (ret) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
        check_all(tag);
    endtask

    localparam logic [3:0] C_NONE  = 4'b0000;
    localparam logic [3:0] C_ALU   = 4'b0001;
    localparam logic [3:0] C_LOAD  = 4'b1011;
    localparam logic [3:0] C_STORE = 4'b0100;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_result_in = '0; store_data_in = '0; rd_in = '0;
        {mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in} = C_NONE;
        #2;
        chk("reset:out_valid", 64'(out_valid), 64'(0));
        chk("reset:in_ready", 64'(in_ready), 64'(1));
        chk("reset:addr", 64'(mem_addr_out), 64'(0));
        chk("reset:occupancy", 64'(occupancy), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // Pass-through.
        step("pt", 1, 32'h10, 32'h0, 5'd3, C_ALU, 1, 0);
        chk("pt:addr_const", 64'(mem_addr_out), 64'h10);
        chk("pt:fwd_rd_const", 64'(fwd_rd), 64'd3);
        chk("pt:fwd_valid_const", 64'(fwd_valid), 64'd1);
        step("pt_drain", 0, 32'h0, 32'h0, 5'd0, C_NONE, 1, 0);

        // Backpressure: two entries stack up, head stays stable.
        step("bp_a", 1, 32'h100, 32'h11, 5'd4, C_ALU, 0, 0);
        step("bp_b", 1, 32'h200, 32'h22, 5'd5, C_ALU, 0, 0);
        chk("bp:occ_full", 64'(occupancy), 64'd2);
        chk("bp:in_ready_low", 64'(in_ready), 64'd0);
        step("bp_hold", 1, 32'h999, 32'h0, 5'd6, C_ALU, 0, 0);
        chk("bp:head_stable", 64'(mem_addr_out), 64'h100);
        step("bp_ret_a", 0, 32'h0, 32'h0, 5'd0, C_NONE, 1, 0);
        chk("bp:second", 64'(mem_addr_out), 64'h200);
        step("bp_ret_b", 0, 32'h0, 32'h0, 5'd0, C_NONE, 1, 0);

        // Flush while full with a same-cycle input that must be dropped.
        step("fl_a", 1, 32'h1A0, 32'h0, 5'd8, C_STORE, 0, 0);
        step("fl_b", 1, 32'h2B0, 32'h0, 5'd9, C_LOAD, 0, 0);
        step("fl_c", 1, 32'h300, 32'h0, 5'd10, C_ALU, 0, 1);
        chk("fl:occ_zero", 64'(occupancy), 64'd0);
        step("fl_after", 0, 32'h0, 32'h0, 5'd0, C_NONE, 1, 0);
        chk("fl:c_absent", 64'(out_valid), 64'd0);

        // Load-use and store to x0.
        step("ld", 1, 32'h40, 32'h0, 5'd7, C_LOAD, 0, 0);
        chk("ld:load_pending", 64'(load_pending), 64'd1);
        chk("ld:fwd_valid", 64'(fwd_valid), 64'd0);
        step("st0", 1, 32'h44, 32'h55, 5'd0, C_STORE | C_ALU, 1, 0);
        chk("st0:reg_write", 64'(reg_write_out), 64'd0);
        chk("st0:fwd_valid", 64'(fwd_valid), 64'd0);

        // Simultaneous accept and retire in ONE.
        step("sim_d", 1, 32'hD00, 32'h0, 5'd12, C_ALU, 1, 0);
        chk("sim:occ", 64'(occupancy), 64'd1);
        chk("sim:head_d", 64'(mem_addr_out), 64'hD00);

        // Reset mid-stall: outputs clear without a clock edge.
        step("rs_a", 1, 32'hA1, 32'hB1, 5'd1, C_LOAD, 0, 0);
        step("rs_b", 1, 32'hA2, 32'hB2, 5'd2, C_ALU, 0, 0);
        in_valid = 1'b0;
        reset = 1'b1;
        #2;
        chk("rs:out_valid", 64'(out_valid), 64'd0);
        chk("rs:addr", 64'(mem_addr_out), 64'd0);
        chk("rs:wdata", 64'(write_data_out), 64'd0);
        chk("rs:rd", 64'(rd_out), 64'd0);
        chk("rs:ctrl", 64'({mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out,
                            fwd_valid, load_pending}), 64'd0);
        chk("rs:in_ready", 64'(in_ready), 64'd1);
        chk("rs:occupancy", 64'(occupancy), 64'd0);
        q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        step("rs_first", 1, 32'hE0, 32'h0, 5'd14, C_ALU, 0, 0);
        chk("rs:latency1", 64'(out_valid), 64'd1);
        step("rs_drain", 0, 32'h0, 32'h0, 5'd0, C_NONE, 1, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step("rnd", ($urandom % 4) != 0, $urandom, $urandom, 5'($urandom % 8),
                 4'($urandom), ($urandom % 3) != 0, ($urandom % 16) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage_reg.md
Name: ex_mem_stage_reg

Overview:
- Parametrised EX->MEM pipeline register. It replaces the free-running EX/DM latch with a valid/ready handshake, stall and flush support, and a two-entry skid buffer.
- It sits between the ALU stage and the data-memory stage.
- It also exports forwarding and load-use hazard information for the EX-stage hazard unit.
- Control bits of empty or flushed slots are forced inactive, so that bubbles never write memory or registers.

Parameters:
- XLEN, 32, width of the ALU result and store data.
- RADDR_W, 5, width of the destination-register index.
- ZERO_REG_WRITABLE, 0, when 0, rd==0 never asserts fwd_valid or reg_write_out.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- flush  in  1  kill all held entries (branch/exception).
- in_valid  in  1  EX presents an instruction.
- in_ready  out  1  stage can accept; registered.
- alu_result_in  in  XLEN  address or ALU value.
- store_data_in  in  XLEN  store write data.
- rd_in  in  RADDR_W  destination register.
- mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in  in  1 each  control.
- out_valid  out  1  MEM slot holds a live instruction.
- out_ready  in  1  MEM consumes this cycle.
- mem_addr_out  out  XLEN.
- write_data_out  out  XLEN.
- rd_out  out  RADDR_W.
- mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out  out  1 each  gated by out_valid.
- fwd_valid  out  1  head entry's result is forwardable.
- fwd_rd  out  RADDR_W.
- fwd_data  out  XLEN.
- load_pending  out  1  head entry is a load to rd!=0 (EX must stall dependants).
- occupancy  out  2  entries held, 0..2.

Behaviour:
- State machine: EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
  - The head slot drives the outputs.
  - The skid slot holds the second entry.
- Definitions: accept = in_valid & in_ready; retire = out_valid & out_ready.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept & !retire -> FULL.
  - ONE + retire & !accept -> EMPTY.
  - ONE + accept & retire -> ONE, with the new entry moved into the head.
  - FULL + retire -> ONE, with the skid entry moved into the head.
  - FULL never accepts.
- in_ready: registered, equals (next_state != FULL). It is 1 out of reset.
- Latency: accept at edge N makes out_valid=1 after edge N when the stage was EMPTY. The stage is strictly in order.
- Stability: while out_valid & !out_ready, all head outputs hold constant.
- Gating:
  - mem_read_out, mem_write_out, reg_write_out and mem_to_reg_out are ANDed with out_valid.
  - reg_write_out is also cleared when rd==0 and ZERO_REG_WRITABLE=0.
- Forwarding:
  - fwd_valid = out_valid & reg_write & !mem_to_reg & (rd!=0).
  - fwd_data = head alu_result; fwd_rd = head rd.
  - load_pending = out_valid & mem_to_reg & reg_write & (rd!=0).
- Flush:
  - Synchronous. At the next edge state becomes EMPTY, in_ready=1 and occupancy=0.
  - An accept in the same cycle is discarded.
  - A retire in the same cycle still completes (MEM already consumed it).
- Reset:
  - Asynchronous and immediate. State=EMPTY, in_ready=1, out_valid=0.
  - All data outputs are 0 and all control outputs are 0.
  - Reset asserted mid-stall discards held entries.
- Data slots update only on accept or shift. There are no enables on invalid slots, so a stale payload behind out_valid=0 is permitted but never observable through the gated controls.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef ex_mem_ctrl_t (mem_read, mem_write, mem_to_reg, reg_write);
  - typedef ex_mem_payload_t (ctrl, rd, alu_result, store_data);
  - enum stage_state_t {EMPTY, ONE, FULL};
  - localparam REG_ZERO = 0.
- One natural sub-module, pipe_skid_buf: a generic two-entry valid/ready skid buffer parametrised by payload width, with flush.
- ex_mem_stage_reg packs and unpacks the payload around it and adds the gating and forwarding logic.

Test Plan:
- Pass-through: out_ready=1; send alu=0x10, rd=3, reg_write=1 -> next cycle out_valid=1, mem_addr_out=0x10, fwd_valid=1, fwd_rd=3, occupancy=1.
- Backpressure:
  - out_ready=0; send A=0x100 then B=0x200 -> occupancy=2 and in_ready=0 after the second edge; the head holds 0x100 stable.
  - Then raise out_ready -> 0x100 then 0x200 retire in order and in_ready returns to 1.
- Flush: FULL with out_ready=0; assert flush together with in_valid (C=0x300) -> next cycle out_valid=0, occupancy=0, all controls 0, and C never appears.
- Load-use: send mem_read=1, mem_to_reg=1, reg_write=1, rd=7 -> load_pending=1 and fwd_valid=0. A store with rd=0 gives reg_write_out=0 and fwd_valid=0.
- Reset mid-stall: FULL, then assert reset between edges -> outputs zero immediately (asynchronously). After release, in_ready=1 and the first new accept appears with latency 1.
- Simultaneous: in ONE state, accept D and retire the head in the same cycle -> occupancy stays 1 and the head becomes D next cycle.
